// File: rtl/dff_pkg.sv
// Shared constants for the dff_sync_rst register family.
package dff_pkg;

    localparam int DFF_WIDTH_MAX  = 1024;
    localparam int DFF_STAGES_MAX = 16;
    localparam int DFF_WIDTH_DEF  = 1;

endpackage : dff_pkg

// File: rtl/dff_stage.sv
// Single WIDTH-bit register with clock enable and synchronous active-low reset.
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH   = DFF_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Reset has priority over enable; with ce low the register holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= RST_VAL;
        end else if (ce) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : dff_stage

// File: rtl/dff_sync_rst.sv
// Parameterizable D register / short pipeline delay: STAGES cascaded
// dff_stage instances sharing clk, rst (active-low, synchronous) and ce.
// Optional simulation checks are compiled in when DFF_SYNC_RST_ASSERT_EN
// is defined; they add no logic to the synthesized datapath.
module dff_sync_rst
    import dff_pkg::*;
#(
    parameter int                       WIDTH   = DFF_WIDTH_DEF,
    parameter logic [DFF_WIDTH_MAX-1:0] RST_VAL = '0,
    parameter int                       STAGES  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset constant sized to the datapath; wider values keep only the LSBs.
    localparam logic [WIDTH-1:0] RST_VAL_W = RST_VAL[WIDTH-1:0];

    // chain[0] is the input, chain[k] is the output of stage k-1.
    logic [WIDTH-1:0] chain [STAGES+1];

    assign chain[0] = d;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            dff_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL_W)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .ce  (ce),
                .d   (chain[gi]),
                .q   (chain[gi+1])
            );
        end
    endgenerate

    assign q = chain[STAGES];

`ifdef DFF_SYNC_RST_ASSERT_EN
    generate
        if (WIDTH < 1 || WIDTH > DFF_WIDTH_MAX) begin : g_width_err
            $error("dff_sync_rst: WIDTH=%0d outside 1..%0d", WIDTH, DFF_WIDTH_MAX);
        end
        if (STAGES < 1 || STAGES > DFF_STAGES_MAX) begin : g_stages_err
            $error("dff_sync_rst: STAGES=%0d outside 1..%0d", STAGES, DFF_STAGES_MAX);
        end
        if (WIDTH < DFF_WIDTH_MAX) begin : g_rst_fit
            if ((RST_VAL >> WIDTH) != '0) begin : g_rst_warn
                $warning("dff_sync_rst: RST_VAL does not fit WIDTH=%0d, truncated", WIDTH);
            end
        end
    endgenerate

    logic seen_rst_reg;

    // Remember that at least one reset edge has occurred.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            seen_rst_reg <= 1'b1;
        end
    end

    // Control inputs must be known at every edge once out of power-up.
    always @(posedge clk) begin
        if (seen_rst_reg === 1'b1 && ($isunknown(ce) || $isunknown(rst))) begin
            $error("dff_sync_rst: ce or rst unknown at clock edge");
        end
    end
`endif

endmodule : dff_sync_rst

// File: tb/tb_dff_sync_rst.sv
// Self-checking bench for dff_sync_rst: a default instance (WIDTH=1,
// STAGES=1) and an 8-bit, 3-stage instance with RST_VAL=8'h5A share the
// same rst/ce. A queue-based model tracks the last STAGES enabled samples
// since the most recent reset.
module tb_dff_sync_rst;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       d1;
    logic [7:0] d8;
    logic       q1;
    logic [7:0] q8;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: samples accepted (rst=1, ce=1) since the last reset edge.
    logic       hist1 [$];
    logic [7:0] hist8 [$];

    dff_sync_rst u_dut_a (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .d   (d1),
        .q   (q1)
    );

    dff_sync_rst #(
        .WIDTH   (8),
        .RST_VAL (8'h5A),
        .STAGES  (3)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .d   (d8),
        .q   (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_a();
        return (hist1.size() >= 1) ? hist1[hist1.size()-1] : 1'b0;
    endfunction

    function automatic logic [7:0] exp_b();
        return (hist8.size() >= 3) ? hist8[hist8.size()-3] : 8'h5A;
    endfunction

    // Drive one clock of stimulus, update the model, compare both instances.
    // dv is an 8-bit value; the 1-bit instance sees its LSB.
    task automatic step(input logic r, input logic c, input logic [7:0] dv, input string tag);
        logic       e1;
        logic [7:0] e8;
        rst = r;
        ce  = c;
        d1  = dv[0];
        d8  = dv;
        @(posedge clk);
        #1;
        if (!r) begin
            hist1.delete();
            hist8.delete();
        end else if (c) begin
            hist1.push_back(dv[0]);
            hist8.push_back(dv);
            while (hist1.size() > 1) void'(hist1.pop_front());
            while (hist8.size() > 3) void'(hist8.pop_front());
        end
        e1 = exp_a();
        e8 = exp_b();
        n_assert++;
        assert (q1 === e1) else begin
            n_fail++;
            $error("FAIL %s_a: q=%b expected=%b", tag, q1, e1);
        end
        n_assert++;
        assert (q8 === e8) else begin
            n_fail++;
            $error("FAIL %s_b: q=%h expected=%h", tag, q8, e8);
        end
        $display("step %-10s rst=%b ce=%b d=%h | q_a=%b q_b=%h", tag, r, c, dv, q1, q8);
    endtask

    // Direct comparison against a value written out in the stimulus.
    task automatic check8(input logic [7:0] want, input string tag);
        n_assert++;
        assert (q8 === want) else begin
            n_fail++;
            $error("FAIL %s: q=%h expected=%h", tag, q8, want);
        end
    endtask

    task automatic check1(input logic want, input string tag);
        n_assert++;
        assert (q1 === want) else begin
            n_fail++;
            $error("FAIL %s: q=%b expected=%b", tag, q1, want);
        end
    endtask

    initial begin
        rst = 1'b0;
        ce  = 1'b0;
        d1  = 1'b0;
        d8  = 8'h00;

        // 1: reset then load zero
        step(1'b0, 1'b0, 8'h00, "reset");
        check1(1'b0, "reset_q_a");
        check8(8'h5A, "reset_q_b");
        step(1'b1, 1'b1, 8'h00, "load0");
        check1(1'b0, "load0_q_a");

        // 2: truncation of 8-bit values to the 1-bit instance
        step(1'b1, 1'b1, 8'hAA, "trunc_aa");
        check1(1'b0, "trunc_aa_q");
        step(1'b1, 1'b1, 8'h55, "trunc_55");
        check1(1'b1, "trunc_55_q");

        // 3: hold with ce low
        step(1'b1, 1'b1, 8'h00, "set0");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 8'hFF, "hold");
            check1(1'b0, "hold_q");
        end
        step(1'b1, 1'b1, 8'hFF, "hold_rel");
        check1(1'b1, "hold_rel_q");

        // 4: reset wins over ce
        step(1'b0, 1'b1, 8'hFF, "rst_prio");
        check1(1'b0, "rst_prio_q");
        step(1'b1, 1'b1, 8'hFF, "rst_rel");
        check1(1'b1, "rst_rel_q");

        // 5a: 3-stage stream
        step(1'b0, 1'b0, 8'h00, "reset5");
        step(1'b1, 1'b1, 8'hAA, "s5_e1");
        step(1'b1, 1'b1, 8'h55, "s5_e2");
        step(1'b1, 1'b1, 8'h0F, "s5_e3");
        check8(8'hAA, "s5_e3_q");
        step(1'b1, 1'b1, 8'h00, "s5_e4");
        check8(8'h55, "s5_e4_q");
        step(1'b1, 1'b1, 8'h00, "s5_e5");
        check8(8'h0F, "s5_e5_q");

        // 5b: reset mid-stream discards in-flight data
        step(1'b0, 1'b0, 8'h00, "reset5b");
        step(1'b1, 1'b1, 8'hAA, "s5b_e1");
        step(1'b1, 1'b1, 8'h55, "s5b_e2");
        step(1'b1, 1'b1, 8'h0F, "s5b_e3");
        step(1'b0, 1'b1, 8'h00, "s5b_rst");
        check8(8'h5A, "s5b_rst_q");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'h00, "s5b_drain");
            n_assert++;
            assert (q8 !== 8'h0F) else begin
                n_fail++;
                $error("FAIL s5b_no_0f: q=%h expected=not 0f", q8);
            end
        end

        // 6: ce toggling with incrementing data
        step(1'b0, 1'b0, 8'h00, "reset6");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, ((i % 2) == 0) ? 1'b1 : 1'b0, 8'(i + 1), "ce_tog");
        end
        check8(8'h03, "ce_tog_q");

        // Glitch on rst between edges must be ignored
        rst = 1'b1; ce = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check8(8'h03, "glitch_q");

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 8'($urandom),
                 "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_dff_sync_rst

// File: doc/dff_sync_rst.md
# dff_sync_rst

Parameterizable D-type register with clock enable and synchronous active-low reset. Used as the basic storage element across the design wherever a gated, reset-able register or short pipeline delay is needed. Holds its value when the enable is deasserted and loads a fixed reset constant on reset.

## Interface
Parameters:
- WIDTH, 1: data width in bits; legal range 1..1024.
- RST_VAL, '0: value loaded on reset; truncated or zero-extended to WIDTH.
- STAGES, 1: number of cascaded register stages; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-low: sampled only at the rising edge of clk, reset when 0.
- ce  input  1  clock enable, active-high, common to all stages.
- d  input  WIDTH  data input.
- q  output  WIDTH  registered data output, i.e. the last stage.

## Operation
- Each stage is a WIDTH-bit register. Stage 0 takes d; stage k takes stage k-1. q is the last stage.
- At each rising clk edge, evaluate in priority order:
  - rst == 0: every stage loads RST_VAL, regardless of ce or d.
  - rst == 1 and ce == 1: every stage loads its input, so the pipeline shifts by one.
  - rst == 1 and ce == 0: every stage holds its value.
- Inputs wider than WIDTH at the instantiation site are truncated to the LSBs by normal port rules. No internal width conversion exists beyond RST_VAL sizing.
- q has no combinational path from d, ce or rst.
- Before the first reset edge, q is undefined (X in simulation). No power-on value is guaranteed.

## Timing
- Latency d to q is STAGES rising edges with ce held high.
- With ce gated, latency counts only edges where ce == 1.
- Reset takes effect at the first rising edge sampling rst == 0.
  - q == RST_VAL immediately after that edge.
  - q stays RST_VAL while rst stays low.
- Reset release: the first edge with rst == 1 and ce == 1 loads d into stage 0. q shows that data STAGES edges later.
- Reset mid-operation discards all in-flight data in every stage at the same edge.
- Simultaneous rst == 0 and ce == 1: reset wins.
- An asynchronous glitch on rst between edges has no effect.

## Configuration
- Macro DFF_SYNC_RST_ASSERT_EN.
- When defined, simulation-only checks are compiled in:
  - elaboration error if WIDTH or STAGES is outside its legal range;
  - warning if RST_VAL does not fit WIDTH;
  - error if ce or rst is X/Z at a rising clk edge after the first reset edge.
- When undefined, no checks exist and the synthesized logic is identical.

## Structure
- Shared package dff_pkg holds:
  - constants DFF_WIDTH_MAX = 1024 and DFF_STAGES_MAX = 16;
  - default-width constant DFF_WIDTH_DEF = 1.
- Sub-module dff_stage: one WIDTH-bit register with clk, rst, ce, d, q and the RST_VAL parameter.
- Top module is a generate loop instantiating STAGES dff_stage instances in a chain.

## Test plan
1. Defaults (WIDTH=1, STAGES=1). Apply rst=0, ce=0, d=0 for one edge, then rst=1, ce=1, d=0 -> q=0 after the edge.
2. WIDTH=1, ce=1, drive d=8'hAA then d=8'h55 (truncated to 0 then 1) -> q=0, then q=1 on successive edges.
3. Hold test: ce=0, d=1 with q=0 -> q stays 0 for 3 edges. Then ce=1 -> q=1 at the next edge.
4. Reset priority: q=1, ce=1, d=1, rst=0 for one edge -> q=0 (RST_VAL). Release rst with ce=1, d=1 -> q=1 one edge later.
5. WIDTH=8, STAGES=3, RST_VAL=8'h5A.
   - Reset -> q=8'h5A.
   - Stream 8'hAA, 8'h55, 8'h0F with ce=1 -> q shows 8'hAA at edge 3, 8'h55 at edge 4, 8'h0F at edge 5.
   - Assert rst=0 at edge 4 -> q=8'h5A at edge 4; 8'h0F never appears.
6. WIDTH=8, STAGES=3, ce toggling 1,0,1,0 with d incrementing from 8'h01 -> q advances only on ce=1 edges; d sampled at ce=0 edges is never seen at q.
